// File: rtl/data_compare4_pkg.sv
// Shared result encoding for the registered magnitude comparator and its consumers.
package data_compare4_pkg;

  typedef logic [2:0] cmp_t;

  localparam cmp_t CMP_GT  = 3'b100;
  localparam cmp_t CMP_LT  = 3'b010;
  localparam cmp_t CMP_EQ  = 3'b001;
  localparam cmp_t CMP_RST = 3'b000;

endpackage

// File: rtl/data_compare4_bit_compare_cell.sv
// One bit position of the MSB-first compare chain.
module bit_compare_cell
  import data_compare4_pkg::*;
(
  input  logic i_a,
  input  logic i_b,
  input  cmp_t i_prev,
  output cmp_t o_result
);

  // A decision already made by a more-significant bit wins over this bit.
  always_comb begin
    o_result = CMP_EQ;
    if ((i_prev == CMP_GT) || (i_prev == CMP_LT)) begin
      o_result = i_prev;
    end else if (i_a && !i_b) begin
      o_result = CMP_GT;
    end else if (!i_a && i_b) begin
      o_result = CMP_LT;
    end
  end

endmodule

// File: rtl/data_compare4.sv
// Registered unsigned magnitude comparator with a lower-stage cascade input (74x85 style).
module data_compare4
  import data_compare4_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  input  cmp_t             iData,
  output cmp_t             oData
);

  cmp_t w_chain [WIDTH:0];
  cmp_t w_next;
  cmp_t r_data;

  assign w_chain[WIDTH] = CMP_EQ;

  genvar gi;
  generate
    for (gi = WIDTH - 1; gi >= 0; gi--) begin : g_cell
      bit_compare_cell u_cell (
        .i_a      (iData_a[gi]),
        .i_b      (iData_b[gi]),
        .i_prev   (w_chain[gi+1]),
        .o_result (w_chain[gi])
      );
    end
  endgenerate

  // Equal operands forward the lower stage verbatim, even non-one-hot codes.
  assign w_next = (w_chain[0] == CMP_EQ) ? iData : w_chain[0];

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_data <= CMP_RST;
    end else begin
      r_data <= w_next;
    end
  end

  assign oData = r_data;

endmodule

// File: tb/tb_data_compare4.sv
// Directed and exhaustive checks for data_compare4 against hand-computed values.
module tb_data_compare4;

  logic       iClk;
  logic       iRst_n;
  logic [3:0] iData_a;
  logic [3:0] iData_b;
  logic [2:0] iData;
  logic [2:0] oData;

  int testsRun;
  int testsFailed;

  data_compare4 #(.WIDTH(4)) dut (
    .iClk    (iClk),
    .iRst_n  (iRst_n),
    .iData_a (iData_a),
    .iData_b (iData_b),
    .iData   (iData),
    .oData   (oData)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Advance to just after the next rising edge.
  task automatic stepEdge();
    @(posedge iClk);
    #1;
  endtask

  task automatic test_reset();
    iRst_n  = 1'b0;
    iData_a = 4'b1000;
    iData_b = 4'b0000;
    iData   = 3'b000;
    repeat (3) stepEdge();
    testsRun++;
    if (oData !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL reset_hold: got %b expected 000", oData);
    end
    iRst_n = 1'b1;
    stepEdge();
    testsRun++;
    if (oData !== 3'b100) begin
      testsFailed++;
      $display("[TB] FAIL reset_release: got %b expected 100", oData);
    end
  endtask

  task automatic test_msb();
    iData   = 3'b000;
    iData_a = 4'b1000;
    iData_b = 4'b0000;
    stepEdge();
    testsRun++;
    if (oData !== 3'b100) begin
      testsFailed++;
      $display("[TB] FAIL msb_gt: got %b expected 100", oData);
    end
    iData_a = 4'b0000;
    iData_b = 4'b1000;
    stepEdge();
    testsRun++;
    if (oData !== 3'b010) begin
      testsFailed++;
      $display("[TB] FAIL msb_lt: got %b expected 010", oData);
    end
  endtask

  task automatic test_lower_bits();
    logic [3:0] ta [6] = '{4'b1100, 4'b1000, 4'b1110, 4'b1100, 4'b1111, 4'b1110};
    logic [3:0] tb [6] = '{4'b1000, 4'b1100, 4'b1100, 4'b1110, 4'b1110, 4'b1111};
    logic [2:0] te [6] = '{3'b100, 3'b010, 3'b100, 3'b010, 3'b100, 3'b010};
    iData = 3'b000;
    for (int i = 0; i < 6; i++) begin
      iData_a = ta[i];
      iData_b = tb[i];
      stepEdge();
      testsRun++;
      if (oData !== te[i]) begin
        testsFailed++;
        $display("[TB] FAIL lower_bits a=%b b=%b: got %b expected %b",
                 ta[i], tb[i], oData, te[i]);
      end
    end
  endtask

  task automatic test_cascade();
    logic [2:0] tc [7] = '{3'b100, 3'b010, 3'b001, 3'b000, 3'b011, 3'b111, 3'b101};
    iData_a = 4'b1000;
    iData_b = 4'b1000;
    for (int i = 0; i < 7; i++) begin
      iData = tc[i];
      stepEdge();
      testsRun++;
      if (oData !== tc[i]) begin
        testsFailed++;
        $display("[TB] FAIL cascade_pass iData=%b: got %b expected %b",
                 tc[i], oData, tc[i]);
      end
    end
  endtask

  task automatic test_latency();
    iData   = 3'b001;
    iData_a = 4'b1000;
    iData_b = 4'b0000;
    stepEdge();
    testsRun++;
    if (oData !== 3'b100) begin
      testsFailed++;
      $display("[TB] FAIL latency_first: got %b expected 100", oData);
    end
    iData_a = 4'b0000;
    iData_b = 4'b1000;
    #3;
    testsRun++;
    if (oData !== 3'b100) begin
      testsFailed++;
      $display("[TB] FAIL latency_hold: got %b expected 100", oData);
    end
    stepEdge();
    testsRun++;
    if (oData !== 3'b010) begin
      testsFailed++;
      $display("[TB] FAIL latency_update: got %b expected 010", oData);
    end
  endtask

  task automatic test_async_reset();
    iData   = 3'b001;
    iData_a = 4'b0101;
    iData_b = 4'b0011;
    stepEdge();
    testsRun++;
    if (oData !== 3'b100) begin
      testsFailed++;
      $display("[TB] FAIL async_pre: got %b expected 100", oData);
    end
    #2;
    iRst_n = 1'b0;
    #1;
    testsRun++;
    if (oData !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL async_assert: got %b expected 000", oData);
    end
    stepEdge();
    testsRun++;
    if (oData !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL async_hold: got %b expected 000", oData);
    end
    iRst_n  = 1'b1;
    iData_a = 4'b0011;
    iData_b = 4'b0011;
    iData   = 3'b001;
    stepEdge();
    testsRun++;
    if (oData !== 3'b001) begin
      testsFailed++;
      $display("[TB] FAIL async_release: got %b expected 001", oData);
    end
  endtask

  task automatic test_exhaustive();
    logic [2:0] cin [3] = '{3'b100, 3'b010, 3'b001};
    logic [2:0] expected;
    int         errs;
    errs = 0;
    for (int c = 0; c < 3; c++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          iData_a = a[3:0];
          iData_b = b[3:0];
          iData   = cin[c];
          if (a > b)      expected = 3'b100;
          else if (a < b) expected = 3'b010;
          else            expected = cin[c];
          stepEdge();
          testsRun++;
          if (oData !== expected) begin
            testsFailed++;
            errs++;
            if (errs <= 10)
              $display("[TB] FAIL exhaustive a=%0d b=%0d iData=%b: got %b expected %b",
                       a, b, cin[c], oData, expected);
          end
        end
      end
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    iRst_n  = 1'b0;
    iData_a = '0;
    iData_b = '0;
    iData   = '0;
    #2;
    test_reset();
    test_msb();
    test_lower_bits();
    test_cascade();
    test_latency();
    test_async_reset();
    test_exhaustive();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
